// File: rtl/data_mem_arbiter_if.sv
// Requester-side port bundle for data_mem_arbiter.
// The requester drives the request fields.
// The arbiter drives the grant and the response.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core
// load/store unit (r0) and the debug/DMA loader (r1).
// One access is in flight at a time: IDLE (grant) -> ACCESS -> RESP.
// Misaligned requests skip the memory and go straight to an error response.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave r0,
  data_mem_arbiter_if.slave r1,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              ptr;        // 1 = r1 wins a tie, 0 = r0 wins a tie
  logic              win;        // port owning the transaction in flight
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              gnt0;
  logic              gnt1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;

  // Grant the single requester, or on a tie the port not granted last.
  // Grants only happen in IDLE and are held off while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (r0.req && r1.req) begin
        gnt1 = ptr;
        gnt0 = !ptr;
      end else if (r0.req) begin
        gnt0 = 1'b1;
      end else if (r1.req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Mux the winning requester's fields so they can be latched on the grant edge.
  always_comb begin
    sel_we    = gnt1 ? r1.we    : r0.we;
    sel_addr  = gnt1 ? r1.addr  : r0.addr;
    sel_wdata = gnt1 ? r1.wdata : r0.wdata;
  end

  // Transaction FSM: latch the request, run one memory cycle, emit one response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            win       <= gnt1;
            ptr       <= gnt0;
            if (sel_addr[1:0] != 2'b00) begin
              state   <= RESP;
              rvalid0 <= gnt0;
              rvalid1 <= gnt1;
              err0    <= gnt0;
              err1    <= gnt1;
              rdata0  <= '0;
              rdata1  <= '0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          state   <= RESP;
          rvalid0 <= !win;
          rvalid1 <= win;
          err0    <= 1'b0;
          err1    <= 1'b0;
          rdata0  <= (!win && !lat_we) ? readData : '0;
          rdata1  <= ( win && !lat_we) ? readData : '0;
        end
        RESP: begin
          state   <= IDLE;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          rdata0  <= '0;
          rdata1  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes and bus are decoded from the state register, so they are
  // zero outside ACCESS and drop immediately when reset is asserted.
  always_comb begin
    memRead   = (state == ACCESS) && !lat_we;
    memWrite  = (state == ACCESS) &&  lat_we;
    address   = (state == ACCESS) ? lat_addr  : '0;
    writeData = (state == ACCESS) ? lat_wdata : '0;
    busy      = (state != IDLE);
  end

  assign r0.gnt    = gnt0;
  assign r1.gnt    = gnt1;
  assign r0.rvalid = rvalid0;
  assign r1.rvalid = rvalid1;
  assign r0.rdata  = rdata0;
  assign r1.rdata  = rdata1;
  assign r0.err    = err0;
  assign r1.err    = err1;

endmodule
